// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Shared board geometry, garbage-insert FSM states, row helper.
// Revision : 1.0
// ============================================================================
package tetris_pkg;

    localparam int BOARD_W    = 20;
    localparam int BOARD_H    = 20;
    localparam int BOARD_BITS = BOARD_W * BOARD_H;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Row y of a board, bit x of the result is column x.
    function automatic logic [BOARD_W-1:0] row_of(input logic [BOARD_BITS-1:0] board,
                                                  input int unsigned            y);
        return board[y*BOARD_W +: BOARD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/garbage_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : garbage_lfsr
// Purpose  : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying per-row holes.
// Revision : 1.0
// ============================================================================
module garbage_lfsr
    import tetris_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign value = r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule
`default_nettype wire

// File: rtl/garbage_row_insert.sv
`default_nettype none
// ============================================================================
// Module   : garbage_row_insert
// Purpose  : Pushes up to MAX_ROWS garbage rows in at the bottom of the board,
//            one row per cycle. Optional macro GARBAGE_LFSR_EN selects a
//            pseudo-random hole per row instead of the latched hole_x.
// Revision : 1.0
// ============================================================================
module garbage_row_insert
    import tetris_pkg::*;
#(
    parameter int WIDTH    = BOARD_W,
    parameter int HEIGHT   = BOARD_H,
    parameter int MAX_ROWS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                n_rows,
    input  logic [4:0]                hole_x,
    input  logic [WIDTH*HEIGHT-1:0]   matrix_in,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   matrix_out,
    output logic                      top_out
);

    localparam int               c_BITS = WIDTH * HEIGHT;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_cnt;
    logic [c_BITS-1:0]   r_matrix;
    logic                r_top;

    logic [2:0]          w_cnt_in;
    logic [4:0]          w_hole_in;
    logic [4:0]          w_row_hole;
    logic [WIDTH-1:0]    w_garbage;
    logic [c_BITS-1:0]   w_shifted;
    logic                w_accept;
    logic                w_shift;

    assign w_cnt_in  = (n_rows > 3'(MAX_ROWS)) ? 3'(MAX_ROWS) : n_rows;
    assign w_hole_in = (hole_x >= 5'(WIDTH)) ? 5'(WIDTH-1) : hole_x;
    assign w_accept  = (r_state == IDLE) && start;
    assign w_shift   = (r_state == SHIFT);

`ifdef GARBAGE_LFSR_EN
    logic [7:0] w_lfsr;

    garbage_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (w_shift),
        .value   (w_lfsr)
    );

    assign w_row_hole = 5'(w_lfsr % 8'(WIDTH));
`else
    logic [4:0] r_hole;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hole <= 5'd0;
        end else if (w_accept) begin
            r_hole <= w_hole_in;
        end
    end

    assign w_row_hole = r_hole;
`endif

    // Row 0 drops off the top; the new garbage row becomes row HEIGHT-1 (MSBs).
    assign w_garbage = ~(c_ONE << w_row_hole);
    assign w_shifted = {w_garbage, r_matrix[c_BITS-1:WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (w_cnt_in == 3'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == 3'd1) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_matrix <= '0;
            r_top    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= w_cnt_in;
            r_matrix <= matrix_in;
            r_top    <= 1'b0;
        end else if (w_shift) begin
            r_cnt    <= r_cnt - 3'd1;
            r_matrix <= w_shifted;
            if (row_of(r_matrix, 0) != '0) begin
                r_top <= 1'b1;
            end
        end
    end

    assign matrix_out = r_matrix;
    assign top_out    = r_top;

endmodule
`default_nettype wire
